// File: rtl/onehot_dispatch_decoder_3x8.sv
// rtl/onehot_dispatch_decoder_3x8.sv - index-to-one-hot dispatcher with ack handshake, timeout and drop counter
module onehot_dispatch_decoder_3x8 #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_in_code,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [7:0] o_out_onehot,
  output logic       o_out_valid,
  input  logic       i_out_ack,
  output logic       o_err,
  input  logic       i_err_clr,
  output logic [7:0] o_drop_cnt,
  output logic [2:0] o_last_code
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_timer;
  logic [7:0] r_onehot;
  logic       r_valid;
  logic       r_err;
  logic [7:0] r_drop_cnt;
  logic [2:0] r_last_code;
  logic       w_accept;
  logic       w_timeout;

  // Qualified events: a code is taken only in IDLE; a timeout only when no ack arrives
  always_comb begin
    w_accept  = (r_state == IDLE) && i_in_valid;
    w_timeout = (r_state == BUSY) && !i_out_ack && (r_timer == TIMER_LAST);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ack wins over timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (i_out_ack)                    w_state_nxt = IDLE;
        else if (r_timer == TIMER_LAST)   w_state_nxt = ERR;
      end
      ERR: begin
        if (i_err_clr) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers: presented line, hold timer, last accepted code
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_onehot    <= 8'h00;
      r_valid     <= 1'b0;
      r_timer     <= 8'h00;
      r_last_code <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_onehot    <= 8'h01 << i_in_code;
            r_valid     <= 1'b1;
            r_last_code <= i_in_code;
            r_timer     <= 8'h00;
          end
        end
        BUSY: begin
          if (i_out_ack || (r_timer == TIMER_LAST)) begin
            r_onehot <= 8'h00;
            r_valid  <= 1'b0;
          end else begin
            r_timer <= r_timer + 8'h01;
          end
        end
        default: begin
          r_onehot <= 8'h00;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag, cleared only from ERR by err_clr
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if ((r_state == ERR) && i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  // Saturating drop counter; survives err_clr, cleared only by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drop_cnt <= 8'h00;
    end else if (w_timeout && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end

  // Output decode
  always_comb begin
    o_in_ready   = (r_state == IDLE);
    o_out_onehot = r_onehot;
    o_out_valid  = r_valid;
    o_err        = r_err;
    o_drop_cnt   = r_drop_cnt;
    o_last_code  = r_last_code;
  end

  // w_accept is kept as a named event for readability of the qualifying logic
  logic w_unused;
  always_comb w_unused = w_accept;

endmodule
